imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//   Pipelined, parametrised immediate generator for the LEGv8 datapath. Extracts the
//   immediate field of a 32-bit instruction word, sign- or zero-extends it to DATA_W,
//   and applies the mode-specific shift. It adds MOVZ/MOVK wide immediates and
//   ADDI/SUBI LSL #12. Sits between decode and the operand mux. It is an elastic
//   valid/ready pipeline of PIPE_STAGES register stages, so it can stall with the core.
// PARAMETERS
//   DATA_W       64  output width; legal 32 or 64; extended results are truncated to DATA_W
//   PIPE_STAGES  2   register stages from input to output; legal 1..4
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high reset
//   in_valid   in   1       inst/imm_sel are valid this cycle
//   in_ready   out  1       stage 1 can accept (in_valid & in_ready = transfer)
//   inst       in   32      full instruction word
//   imm_sel    in   3       0 ALU_I, 1 D_TYPE, 2 B, 3 CB, 4 MOV_W, 5-7 illegal
//   out_valid  out  1       imm/err valid
//   out_ready  in   1       consumer accepts (out_valid & out_ready = transfer)
//   imm        out  DATA_W  extended immediate
//   err        out  1       imm_sel was illegal for this item
// BEHAVIOUR
//   Clock and reset: one clock. reset is sampled on the clk edge and is active-high.
//     While reset is high, every stage valid bit is cleared.
//     Outputs after reset: out_valid=0, imm=0, err=0, in_ready=1.
//     Reset asserted mid-stream drops every in-flight item. No partial output is produced.
//   Datapath: the result is computed combinationally from inst/imm_sel and captured in
//     stage 1. Later stages only move data forward. The imm output comes straight from
//     the last-stage register, with no combinational path from inst to imm.
//   Modes (sx = sign-extend, zx = zero-extend, then truncate to DATA_W):
//     ALU_I   zx(inst[21:10]) << (inst[22] ? 12 : 0)
//     D_TYPE  sx(inst[20:12])
//     B       sx(inst[25:0]) << 2
//     CB      sx(inst[23:5]) << 2
//     MOV_W   zx(inst[20:5]) << (16*inst[22:21])
//       If DATA_W=32 and inst[22]=1, the result is imm=0 and err=1.
//     5..7    imm=0, err=1
//   Handshake:
//     Stage k advances when it is empty or stage k+1 advances. The last stage advances
//       when it is empty or out_ready=1.
//     in_ready = stage 1 advances. It is combinational from out_ready through the chain.
//     A full pipeline with out_ready=1 sustains 1 item per clock.
//     Latency is exactly PIPE_STAGES cycles from accept to out_valid when there are no stalls.
//     While out_valid=1 and out_ready=0, imm and err are held stable.
//     The valid bits are not dropped and items are not reordered or duplicated.
//     Capacity is PIPE_STAGES items. With out_ready=0, in_ready falls after
//       PIPE_STAGES accepts.
//     Simultaneous accept and drain on a full pipeline is legal. Occupancy stays unchanged.
//   An empty stage's data registers may update freely. The registers are compared only
//     when their stage is valid.
// TESTING
//   T1 ALU_I: inst[21:10]=0xFFF, inst[22]=0 -> imm=0x0000_0000_0000_0FFF
//      With inst[22]=1 -> imm=0x0000_0000_00FF_F000
//   T2 D_TYPE: inst[20:12]=0x100 -> imm=0xFFFF_FFFF_FFFF_FF00
//      B: inst[25:0]=0x3FF_FFFF -> imm=0xFFFF_FFFF_FFFF_FFFC
//      CB: inst[23:5]=0x40000 -> imm=0xFFFF_FFFF_FFF0_0000
//   T3 MOV_W: inst[20:5]=0xBEEF, inst[22:21]=3 -> imm=0xBEEF_0000_0000_0000
//      With DATA_W=32: hw=1 -> 0xBEEF_0000; hw=2 -> imm=0, err=1
//   T4 imm_sel=5,6,7 -> imm=0, err=1, and the following item still flows normally
//   T5 Throughput and latency, PIPE_STAGES=2, out_ready=1:
//      10 back-to-back items -> out_valid first at cycle 2 after the first accept,
//      then 10 consecutive results in order
//   T6 Stall: hold out_ready=0 -> 2 accepts, then in_ready=0, with imm stable across 5 cycles
//      Release -> results drain in order with no loss
//      Assert reset with 2 items in flight -> out_valid=0 next cycle, in_ready=1

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: LEGv8 immediate generator behind an elastic valid/ready pipeline.
module imm_gen_pipe #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [2:0]        imm_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output logic              err
);

  typedef enum logic [2:0] {
    SEL_ALU_I  = 3'd0,
    SEL_D_TYPE = 3'd1,
    SEL_B      = 3'd2,
    SEL_CB     = 3'd3,
    SEL_MOV_W  = 3'd4
  } imm_sel_e;

  logic [63:0]             full_c;
  logic [DATA_W-1:0]       imm_c;
  logic                    err_c;
  logic                    unused_inst;

  logic [PIPE_STAGES-1:0]  valid_q, valid_d;
  logic [PIPE_STAGES-1:0]  adv;
  logic [DATA_W-1:0]       imm_q [PIPE_STAGES];
  logic [DATA_W-1:0]       imm_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]  err_q, err_d;

  always_comb begin
    unused_inst = ^inst[31:26];
  end

  // Extend at full 64-bit width first, then truncate to DATA_W.
  always_comb begin
    full_c = '0;
    err_c  = 1'b0;
    case (imm_sel)
      SEL_ALU_I:  full_c = {52'd0, inst[21:10]} << (inst[22] ? 6'd12 : 6'd0);
      SEL_D_TYPE: full_c = {{55{inst[20]}}, inst[20:12]};
      SEL_B:      full_c = {{38{inst[25]}}, inst[25:0]} << 2;
      SEL_CB:     full_c = {{45{inst[23]}}, inst[23:5]} << 2;
      SEL_MOV_W: begin
        if (DATA_W == 32 && inst[22]) begin
          err_c = 1'b1;
        end else begin
          full_c = {48'd0, inst[20:5]} << {inst[22:21], 4'd0};
        end
      end
      default:    err_c = 1'b1;
    endcase
    imm_c = full_c[DATA_W-1:0];
  end

  // Advance chain is resolved from the output back to stage 0 via a running carry
  // so no vector bit depends on another bit of itself.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = out_ready;
    for (int unsigned k = PIPE_STAGES; k > 0; k--) begin
      adv[k-1] = !valid_q[k-1] || carry;
      carry    = adv[k-1];
    end

    valid_d = valid_q;
    err_d   = err_q;
    for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
      imm_d[k] = imm_q[k];
    end

    if (adv[0]) begin
      valid_d[0] = in_valid;
      imm_d[0]   = imm_c;
      err_d[0]   = err_c;
    end
    for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k] = valid_q[k-1];
        imm_d[k]   = imm_q[k-1];
        err_d[k]   = err_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
        imm_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
        imm_q[k] <= imm_d[k];
      end
    end
  end

  always_comb begin
    in_ready  = adv[0];
    out_valid = valid_q[PIPE_STAGES-1];
    imm       = imm_q[PIPE_STAGES-1];
    err       = err_q[PIPE_STAGES-1];
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: 64-bit and 32-bit instances, directed vectors.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0] inst;
  logic [2:0]  imm_sel;
  logic [63:0] imm;

  logic        in_valid_32, in_ready_32, out_valid_32, out_ready_32, err_32;
  logic [31:0] inst_32;
  logic [2:0]  imm_sel_32;
  logic [31:0] imm_32;

  imm_gen_pipe #(.DATA_W(64), .PIPE_STAGES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .imm_sel(imm_sel), .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .err(err)
  );

  imm_gen_pipe #(.DATA_W(32), .PIPE_STAGES(2)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid_32), .in_ready(in_ready_32),
    .inst(inst_32), .imm_sel(imm_sel_32), .out_valid(out_valid_32),
    .out_ready(out_ready_32), .imm(imm_32), .err(err_32)
  );

  typedef struct {
    logic [63:0] imm;
    logic        err;
    int unsigned acc;
    bit          lat;
  } exp_t;

  exp_t        q64[$];
  exp_t        q32[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          lat_mode = 1'b1;
  int unsigned stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon64
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m64_unexpected: got output %h expected none", imm);
      end else begin
        e = q64.pop_front();
        check("m64_imm", imm, e.imm);
        check("m64_err", {63'd0, err}, {63'd0, e.err});
        if (e.lat) check("m64_latency", 64'(cyc - e.acc), 64'd2);
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!reset && out_valid_32 && out_ready_32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m32_unexpected: got output %h expected none", imm_32);
      end else begin
        e = q32.pop_front();
        check("m32_imm", {32'd0, imm_32}, e.imm);
        check("m32_err", {63'd0, err_32}, {63'd0, e.err});
        if (e.lat) check("m32_latency", 64'(cyc - e.acc), 64'd2);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bit w32, input logic [31:0] i, input logic [2:0] s,
                      input logic [63:0] ei, input logic ee);
    int unsigned n = 0;
    exp_t e;
    if (w32) begin
      in_valid_32 = 1'b1; inst_32 = i; imm_sel_32 = s;
    end else begin
      in_valid = 1'b1; inst = i; imm_sel = s;
    end
    @(negedge clk);
    while (!(w32 ? in_ready_32 : in_ready)) begin
      stall_cnt++;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        in_valid = 1'b0;
        in_valid_32 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.imm = ei; e.err = ee; e.acc = cyc; e.lat = lat_mode;
    if (w32) q32.push_back(e); else q64.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_valid_32 = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((q64.size() != 0 || q32.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 64'(q64.size() + q32.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; inst = '0; imm_sel = '0; out_ready = 1'b1;
    in_valid_32 = 1'b0; inst_32 = '0; imm_sel_32 = '0; out_ready_32 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_imm", imm, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid_32", {63'd0, out_valid_32}, 64'd0);
    @(posedge clk); #1;

    // ALU_I, with and without LSL #12
    send(0, 32'h913F_FC00, 3'd0, 64'h0000_0000_0000_0FFF, 1'b0);
    send(0, 32'h007F_FC00, 3'd0, 64'h0000_0000_00FF_F000, 1'b0);
    // D_TYPE negative/positive, B, CB
    send(0, 32'hF810_0ABC, 3'd1, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
    send(0, 32'h000F_F000, 3'd1, 64'h0000_0000_0000_00FF, 1'b0);
    send(0, 32'h17FF_FFFF, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(0, 32'h1400_0123, 3'd2, 64'h0000_0000_0000_048C, 1'b0);
    send(0, 32'hB480_0000, 3'd3, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
    send(0, 32'hB400_00A3, 3'd3, 64'h0000_0000_0000_0014, 1'b0);
    // MOV_W, all four halfword positions
    send(0, 32'hD297_DDE0, 3'd4, 64'h0000_0000_0000_BEEF, 1'b0);
    send(0, 32'hD2B7_DDE0, 3'd4, 64'h0000_0000_BEEF_0000, 1'b0);
    send(0, 32'hD2D7_DDE0, 3'd4, 64'h0000_BEEF_0000_0000, 1'b0);
    send(0, 32'hD2F7_DDE0, 3'd4, 64'hBEEF_0000_0000_0000, 1'b0);
    // illegal selectors, then a normal item
    send(0, 32'hFFFF_FFFF, 3'd5, 64'd0, 1'b1);
    send(0, 32'h1234_5678, 3'd6, 64'd0, 1'b1);
    send(0, 32'h17FF_FFFF, 3'd7, 64'd0, 1'b1);
    send(0, 32'h0000_1400, 3'd0, 64'h0000_0000_0000_0005, 1'b0);

    // DATA_W=32 instance
    send(1, 32'hD297_DDE0, 3'd4, 64'h0000_0000_0000_BEEF, 1'b0);
    send(1, 32'hD2B7_DDE0, 3'd4, 64'h0000_0000_BEEF_0000, 1'b0);
    send(1, 32'hD2D7_DDE0, 3'd4, 64'd0, 1'b1);
    send(1, 32'h17FF_FFFF, 3'd2, 64'h0000_0000_FFFF_FFFC, 1'b0);
    send(1, 32'h007F_FC00, 3'd0, 64'h0000_0000_00FF_F000, 1'b0);
    send(1, 32'h0000_0000, 3'd7, 64'd0, 1'b1);
    drain();

    // back-to-back throughput with out_ready held high
    stall_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      send(0, 32'((i * 16 + 3) << 10), 3'd0, 64'(i * 16 + 3), 1'b0);
    end
    check("t5_in_ready_stalls", 64'(stall_cnt), 64'd0);
    drain();

    // stall: capacity two, output held
    lat_mode = 1'b0;
    out_ready = 1'b0;
    send(0, 32'hF810_0ABC, 3'd1, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
    send(0, 32'h000F_F000, 3'd1, 64'h0000_0000_0000_00FF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check("stall_imm", imm, 64'hFFFF_FFFF_FFFF_FF00);
      check("stall_err", {63'd0, err}, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(0, 32'hB480_0000, 3'd3, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
    send(0, 32'h0000_0C00, 3'd0, 64'h0000_0000_0000_0003, 1'b0);
    drain();

    // reset with two items in flight
    out_ready = 1'b0;
    send(0, 32'h17FF_FFFF, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(0, 32'hD2F7_DDE0, 3'd4, 64'hBEEF_0000_0000_0000, 1'b0);
    @(negedge clk);
    check("pre_reset_out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q64.delete();
    check("post_reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_reset_imm", imm, 64'd0);
    out_ready = 1'b1;
    lat_mode = 1'b1;
    send(0, 32'h1400_0123, 3'd2, 64'h0000_0000_0000_048C, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
